twos_to_true_form: RTL and testbench



---
 rtl/twos_pkg.sv | 17 +
 rtl/twos_negate_core.sv | 37 +++
 rtl/twos_to_true_form.sv | 54 +++++
 tb/tb_twos_to_true_form.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/twos_pkg.sv
// Shared constants, helpers and types for the two's-complement to sign-magnitude converter.
package twos_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Most-negative two's-complement code of a given width: MSB set, all other bits clear.
  function automatic logic [63:0] most_neg_code(input int unsigned width);
    return 64'd1 << (width - 32'd1);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic                     ovf;
    logic [DEFAULT_WIDTH-1:0] data;
  } result_t;

endpackage

// File: rtl/twos_negate_core.sv
// Combinational two's-complement to sign-magnitude conversion.
// Build option TWOS_SAT_EN makes the most-negative code saturate to all ones.
module twos_negate_core
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg_code(WIDTH));

  logic [WIDTH-2:0] mag_neg_s;

  // Magnitude of a negative operand wraps modulo 2^(WIDTH-1), so the most-negative code yields zero.
  always_comb begin
    mag_neg_s = ~in[WIDTH-2:0] + (WIDTH-1)'(1'b1);
    ovf       = (in == MOST_NEG);
    res       = in;
    if (in[WIDTH-1]) begin
`ifdef TWOS_SAT_EN
      if (ovf) begin
        res = {WIDTH{1'b1}};
      end else begin
        res = {1'b1, mag_neg_s};
      end
`else
      res = {1'b1, mag_neg_s};
`endif
    end else begin
      res = in;
    end
  end

endmodule

// File: rtl/twos_to_true_form.sv
// Registered two's-complement to true-form (sign-magnitude) converter, one cycle latency.
// Optional build macro: TWOS_SAT_EN (saturate the most-negative input instead of negative zero).
module twos_to_true_form
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] abs_out,
  output logic             ovf
);

  logic [WIDTH-1:0] res_s;
  logic             ovf_s;

  logic             valid_r;
  logic             ovf_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] abs_r;

  twos_negate_core #(.WIDTH(WIDTH)) u_core (
    .in  (in),
    .res (res_s),
    .ovf (ovf_s)
  );

  // Result pipeline stage; data holds across idle cycles so downstream can keep sampling it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      abs_r   <= {WIDTH{1'b0}};
    end else if (in_valid) begin
      valid_r <= 1'b1;
      ovf_r   <= ovf_s;
      data_r  <= res_s;
      abs_r   <= {1'b0, res_s[WIDTH-2:0]};
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign ovf       = ovf_r;
  assign out       = data_r;
  assign abs_out   = abs_r;

endmodule

// File: tb/tb_twos_to_true_form.sv
// Self-checking bench for twos_to_true_form (WIDTH=16): directed test-plan steps then random traffic.
module tb_twos_to_true_form;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in;
  logic        out_valid;
  logic [15:0] out;
  logic [15:0] abs_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [15:0] exp_out;
  logic        exp_ovf;

  twos_to_true_form #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .abs_out   (abs_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: returns {ovf, sign-magnitude value} from the signed integer value of x.
  function automatic logic [16:0] ref_conv(input logic [15:0] x);
    int v;
    int m;
    v = $signed(x);
    if (v >= 0) return {1'b0, x};
    m = -v;
    if (m == 32768) begin
`ifdef TWOS_SAT_EN
      return {1'b1, 16'hFFFF};
`else
      return {1'b1, 16'h8000};
`endif
    end
    return {1'b0, 16'h8000 | 16'(m)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d);
    logic [16:0] m;
    rst      = r;
    in_valid = v;
    in       = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0;
      exp_out   = 16'h0000;
      exp_ovf   = 1'b0;
    end else if (v) begin
      m         = ref_conv(d);
      exp_valid = 1'b1;
      exp_out   = m[15:0];
      exp_ovf   = m[16];
    end else begin
      exp_valid = 1'b0;
    end
    check("out_valid", {15'd0, out_valid}, {15'd0, exp_valid});
    check("out", out, exp_out);
    check("abs_out", abs_out, {1'b0, exp_out[14:0]});
    check("ovf", {15'd0, ovf}, {15'd0, exp_ovf});
  endtask

  initial begin
    logic [15:0] r16;
    logic [16:0] a;
    logic [16:0] b;
    exp_valid = 1'b0;
    exp_out   = 16'h0000;
    exp_ovf   = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in = 16'h0000;
    #2;
    step(1'b1, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 16'h0005);
    check("tp_pos", out, 16'h0005);
    step(1'b0, 1'b1, 16'h0000);
    check("tp_zero", out, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFB);
    check("tp_neg5", out, 16'h8005);
    step(1'b0, 1'b1, 16'h8001);
    check("tp_8001", out, 16'hFFFF);
    check("tp_8001_abs", abs_out, 16'h7FFF);
    step(1'b0, 1'b1, 16'hFFFF);
    check("tp_ffff", out, 16'h8001);
    step(1'b0, 1'b1, 16'h8000);
    check("tp_mneg_ovf", {15'd0, ovf}, 16'h0001);
`ifdef TWOS_SAT_EN
    check("tp_mneg_out", out, 16'hFFFF);
    check("tp_mneg_abs", abs_out, 16'h7FFF);
`else
    check("tp_mneg_out", out, 16'h8000);
    check("tp_mneg_abs", abs_out, 16'h0000);
`endif

    step(1'b0, 1'b1, 16'h0003);
    check("tp_stream0", out, 16'h0003);
    step(1'b0, 1'b1, 16'hFFFD);
    check("tp_stream1", out, 16'h8003);
    step(1'b0, 1'b1, 16'h7FFF);
    check("tp_stream2", out, 16'h7FFF);

    step(1'b0, 1'b0, 16'h1234);
    check("tp_hold", out, 16'h7FFF);
    step(1'b0, 1'b0, 16'hFFFB);

    step(1'b1, 1'b1, 16'hFFFB);
    step(1'b0, 1'b1, 16'hFFFB);
    check("tp_resume", out, 16'h8005);

    for (int i = 0; i < 300; i++) begin
      r16 = 16'($urandom);
      if ((i % 7) == 3) r16 = 16'h8000;
      if ((i % 11) == 5) r16 = 16'h0000;
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, r16);
    end

    // Self-inverse property of the reference on non-extreme codes, cross-checked on the DUT.
    for (int i = 0; i < 20; i++) begin
      r16 = 16'($urandom);
      if (r16 == 16'h8000) r16 = 16'h8001;
      step(1'b0, 1'b1, r16);
      a = {1'b0, out};
      step(1'b0, 1'b1, a[15:0]);
      b = {1'b0, out};
      check("self_inverse", b[15:0], r16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
